id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 5, register-index width.
REQ-002 SHALL have parameter DWIDTH, default 32, operand/immediate/PC width.
REQ-003 SHALL have parameter MUL_LAT, default 3, EX occupancy in cycles of a multiply (legal 2..15).
REQ-004 SHALL have port clk  input  1  single clock, all state rising-edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports RegS1D, RegS2D, WriteRegD  input  WIDTH  decode rs1/rs2/rd.
REQ-007 SHALL have ports RD1D, RD2D, ImmD, PCD  input  DWIDTH  decode operands, immediate, PC.
REQ-008 SHALL have ports RegWD, MemReadD, MemWriteD, ALUSrcD, MulD, ValidD  input  1 each  decode control bits.
REQ-009 SHALL have port ALUCtrlD  input  4  decode ALU opcode.
REQ-010 SHALL have port FlushE  input  1  branch taken in EX, kill ID/EX contents.
REQ-011 SHALL have ports RegS1E, RegS2E, WriteRegE  output  WIDTH  registered indices feeding the forwarding unit.
REQ-012 SHALL have ports RD1E, RD2E, ImmE, PCE  output  DWIDTH; RegWE, MemReadE, MemWriteE, ALUSrcE, MulE, ValidE  output  1; ALUCtrlE  output  4; all registered copies.
REQ-013 SHALL have ports StallF, StallD  output  1  hold PC and IF/ID register.
REQ-014 SHALL have port BusyE  output  1  multiply in progress.
REQ-015 SHALL have port StallCount  output  16  saturating count of stalled cycles.

Function
REQ-016 SHALL compute LoadUse = ValidE & MemReadE & (WriteRegE != 0) & ((WriteRegE == RegS1D) | (WriteRegE == RegS2D)), combinationally.
REQ-017 SHALL keep FSM states RUN and MUL_BUSY, plus a 4-bit down-counter MulCnt.
REQ-018 SHALL apply per-edge priority: FlushE > MUL_BUSY hold > LoadUse bubble > normal capture.
REQ-019 SHALL, on FlushE=1, load a bubble: all E outputs zero, ValidE=0, state RUN, MulCnt=0, regardless of state.
REQ-020 SHALL, in RUN with LoadUse=1 and FlushE=0, load a bubble and assert StallF=StallD=1 that same cycle; the load-use stall lasts exactly one cycle.
REQ-021 SHALL, in RUN with no flush/LoadUse, capture all D inputs into E registers; if MulD&ValidD captured, go MUL_BUSY with MulCnt=MUL_LAT-1.
REQ-022 SHALL, in MUL_BUSY, hold all E registers, assert BusyE=StallF=StallD=1, decrement MulCnt; at MulCnt==1 the next edge returns to RUN (EX occupied MUL_LAT cycles total).
REQ-023 SHALL treat an instruction captured with ValidD=0 as a bubble (MulD ignored).
REQ-024 SHALL compute StallF/StallD combinationally as (state==MUL_BUSY & ~FlushE) | (state==RUN & LoadUse & ~FlushE).
REQ-025 SHALL increment StallCount on each edge where StallD=1, saturating at 16'hFFFF.
REQ-026 SHALL exclude x0 from LoadUse (rd=0 never stalls).

Reset
REQ-027 SHALL, while rst=0, asynchronously force all E outputs to 0, ValidE=0, state RUN, MulCnt=0, StallCount=0.
REQ-028 SHALL, during reset, drive StallF=StallD=BusyE=0; a reset mid-multiply abandons it without further stall.
REQ-029 SHALL capture normally on the first rising edge after rst deasserts.

Structure
REQ-030 SHALL place the state enum (RUN, MUL_BUSY), a packed control struct (RegW, MemRead, MemWrite, ALUSrc, Mul, Valid, ALUCtrl) and default MUL_LAT in shared package pipe_pkg.
REQ-031 SHALL implement REQ-016 in one sub-module load_use_detect, instantiated once.

Verification
REQ-032 SHALL test: reset with rst=0 mid-MUL_BUSY -> all outputs 0 immediately, StallD=0, StallCount=0.
REQ-033 SHALL test: E holds lw x9 (MemReadE=1, WriteRegE=9), D has RegS1D=9 -> StallF=StallD=1 one cycle, next ValidE=0, following cycle RegS1E=9 captured.
REQ-034 SHALL test: same as REQ-033 with WriteRegE=0 -> no stall, direct capture.
REQ-035 SHALL test: mul captured with MUL_LAT=3 -> BusyE=1 for 2 cycles, E held 3 cycles, StallCount += 2.
REQ-036 SHALL test: FlushE=1 concurrent with LoadUse=1 -> StallD=0, bubble loaded, no StallCount increment.
REQ-037 SHALL test: force StallCount=16'hFFFE plus 3 stalled cycles -> reads 16'hFFFF.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline state encoding, ID/EX control bundle and default multiply latency
package pipe_pkg;
  typedef enum logic {RUN, MUL_BUSY} state_t;
  typedef struct packed {
    logic RegW;
    logic MemRead;
    logic MemWrite;
    logic ALUSrc;
    logic Mul;
    logic Valid;
    logic [3:0] ALUCtrl;
  } ctrl_t;
  localparam int MUL_LAT_DEF = 3;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags a valid load in EX whose non-x0 rd matches either source register in ID
module load_use_detect #(
  parameter int WIDTH = 5
) (
  input  logic             valid_e,
  input  logic             mem_read_e,
  input  logic [WIDTH-1:0] write_reg_e,
  input  logic [WIDTH-1:0] reg_s1_d,
  input  logic [WIDTH-1:0] reg_s2_d,
  output logic             load_use
);
  assign load_use = valid_e & mem_read_e & (write_reg_e != '0) &
                    ((write_reg_e == reg_s1_d) | (write_reg_e == reg_s2_d));
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with flush, load-use bubble, multi-cycle multiply hold and saturating stall counter
module id_ex_stage import pipe_pkg::*; #(
  parameter int WIDTH   = 5,
  parameter int DWIDTH  = 32,
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  RegS1D,
  input  logic [WIDTH-1:0]  RegS2D,
  input  logic [WIDTH-1:0]  WriteRegD,
  input  logic [DWIDTH-1:0] RD1D,
  input  logic [DWIDTH-1:0] RD2D,
  input  logic [DWIDTH-1:0] ImmD,
  input  logic [DWIDTH-1:0] PCD,
  input  logic              RegWD,
  input  logic              MemReadD,
  input  logic              MemWriteD,
  input  logic              ALUSrcD,
  input  logic              MulD,
  input  logic              ValidD,
  input  logic [3:0]        ALUCtrlD,
  input  logic              FlushE,
  output logic [WIDTH-1:0]  RegS1E,
  output logic [WIDTH-1:0]  RegS2E,
  output logic [WIDTH-1:0]  WriteRegE,
  output logic [DWIDTH-1:0] RD1E,
  output logic [DWIDTH-1:0] RD2E,
  output logic [DWIDTH-1:0] ImmE,
  output logic [DWIDTH-1:0] PCE,
  output logic              RegWE,
  output logic              MemReadE,
  output logic              MemWriteE,
  output logic              ALUSrcE,
  output logic              MulE,
  output logic              ValidE,
  output logic [3:0]        ALUCtrlE,
  output logic              StallF,
  output logic              StallD,
  output logic              BusyE,
  output logic [15:0]       StallCount
);
  typedef struct packed {
    ctrl_t c;
    logic [WIDTH-1:0] s1, s2, wr;
    logic [DWIDTH-1:0] rd1, rd2, imm, pc;
  } ex_t;
  state_t state, state_nxt;
  logic [3:0] mul_cnt, cnt_nxt;
  logic [15:0] stall_cnt;
  ex_t d, e, e_nxt;
  logic load_use, run, hold_mul, go_mul;
  assign d = {RegWD, MemReadD, MemWriteD, ALUSrcD, MulD, ValidD, ALUCtrlD,
              RegS1D, RegS2D, WriteRegD, RD1D, RD2D, ImmD, PCD};
  load_use_detect #(.WIDTH(WIDTH)) u_lud (
    .valid_e(e.c.Valid),
    .mem_read_e(e.c.MemRead),
    .write_reg_e(e.wr),
    .reg_s1_d(RegS1D),
    .reg_s2_d(RegS2D),
    .load_use(load_use)
  );
  assign run      = state == RUN;
  assign hold_mul = ~run & ~FlushE;
  assign go_mul   = run & ~FlushE & ~load_use & ValidD & MulD;
  assign StallD   = hold_mul | (run & load_use & ~FlushE);
  assign StallF   = StallD;
  assign BusyE    = ~run;
  always_comb begin
    e_nxt     = (FlushE | (run & (load_use | ~ValidD))) ? '0 : run ? d : e;
    state_nxt = (go_mul | (hold_mul & mul_cnt != 4'd1)) ? MUL_BUSY : RUN;
    cnt_nxt   = go_mul ? 4'(MUL_LAT - 1) : hold_mul ? mul_cnt - 4'd1 : 4'd0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= RUN;
      mul_cnt   <= '0;
      e         <= '0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      mul_cnt   <= cnt_nxt;
      e         <= e_nxt;
      stall_cnt <= stall_cnt + 16'(StallD & ~&stall_cnt);
    end
  assign {RegWE, MemReadE, MemWriteE, ALUSrcE, MulE, ValidE, ALUCtrlE,
          RegS1E, RegS2E, WriteRegE, RD1E, RD2E, ImmE, PCE} = e;
  assign StallCount = stall_cnt;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for id_ex_stage covering reset, load-use, x0, multiply hold, flush and counter saturation
module tb_id_ex_stage;
  typedef logic [42:0] snap_t;
  logic clk, rst;
  logic [4:0] RegS1D, RegS2D, WriteRegD, RegS1E, RegS2E, WriteRegE;
  logic [31:0] RD1D, RD2D, ImmD, PCD, RD1E, RD2E, ImmE, PCE;
  logic RegWD, MemReadD, MemWriteD, ALUSrcD, MulD, ValidD, FlushE;
  logic RegWE, MemReadE, MemWriteE, ALUSrcE, MulE, ValidE;
  logic [3:0] ALUCtrlD, ALUCtrlE;
  logic StallF, StallD, BusyE;
  logic [15:0] StallCount, exp_cnt;
  int tests, fails;
  snap_t exp_q[$];
  snap_t got, exp;
  id_ex_stage dut (
    .clk(clk), .rst(rst),
    .RegS1D(RegS1D), .RegS2D(RegS2D), .WriteRegD(WriteRegD),
    .RD1D(RD1D), .RD2D(RD2D), .ImmD(ImmD), .PCD(PCD),
    .RegWD(RegWD), .MemReadD(MemReadD), .MemWriteD(MemWriteD), .ALUSrcD(ALUSrcD),
    .MulD(MulD), .ValidD(ValidD), .ALUCtrlD(ALUCtrlD), .FlushE(FlushE),
    .RegS1E(RegS1E), .RegS2E(RegS2E), .WriteRegE(WriteRegE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmE(ImmE), .PCE(PCE),
    .RegWE(RegWE), .MemReadE(MemReadE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE),
    .MulE(MulE), .ValidE(ValidE), .ALUCtrlE(ALUCtrlE),
    .StallF(StallF), .StallD(StallD), .BusyE(BusyE), .StallCount(StallCount)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  function automatic snap_t snap();
    return {ValidE, RegS1E, RegS2E, WriteRegE, MemReadE, MulE, RD1E[7:0], BusyE, StallCount};
  endfunction
  function automatic snap_t mk(input logic v, input logic [4:0] s1, s2, wr, input logic mr, mul,
                               input logic [7:0] rd1, input logic busy, input logic [15:0] cnt);
    return {v, s1, s2, wr, mr, mul, rd1, busy, cnt};
  endfunction
  function automatic snap_t bubble(input logic [15:0] cnt);
    return {27'd0, cnt};
  endfunction
  task automatic set_d(input logic [4:0] s1, s2, wr, input logic [7:0] rd1, input logic mr, mul, valid);
    RegS1D = s1; RegS2D = s2; WriteRegD = wr; RD1D = {24'h0, rd1};
    RD2D = 32'h1234; ImmD = 32'h10; PCD = 32'h400; ALUCtrlD = 4'h2;
    RegWD = 1'b1; MemWriteD = 1'b0; ALUSrcD = mr; MemReadD = mr; MulD = mul; ValidD = valid;
  endtask
  task automatic test_reset();
    set_d(0, 0, 0, 0, 0, 0, 0);
    FlushE = 0;
    rst = 0;
    exp_cnt = 0;
    #2;
    tests++;
    if (snap() !== 43'd0 || {StallF, StallD, BusyE} !== 3'b000) begin
      fails++;
      $display("FAIL reset_state got=%h stall=%b exp=0", snap(), {StallF, StallD, BusyE});
    end
    @(negedge clk);
    rst = 1;
    set_d(3, 4, 5, 8'h66, 0, 0, 1);
    exp_q.push_back(mk(1, 3, 4, 5, 0, 0, 8'h66, 0, exp_cnt));
    @(posedge clk); #1;
    got = snap(); exp = exp_q.pop_front(); tests++;
    if (got !== exp) begin fails++; $display("FAIL first_capture got=%h exp=%h", got, exp); end
  endtask
  task automatic test_load_use();
    @(negedge clk);
    set_d(1, 2, 9, 8'h11, 1, 0, 1);
    exp_q.push_back(mk(1, 1, 2, 9, 1, 0, 8'h11, 0, exp_cnt));
    @(posedge clk); #1;
    got = snap(); exp = exp_q.pop_front(); tests++;
    if (got !== exp) begin fails++; $display("FAIL lu_load got=%h exp=%h", got, exp); end
    @(negedge clk);
    set_d(9, 3, 4, 8'h22, 0, 0, 1);
    #1; tests++;
    if ({StallF, StallD} !== 2'b11) begin fails++; $display("FAIL lu_stall got=%b exp=11", {StallF, StallD}); end
    exp_cnt++;
    exp_q.push_back(bubble(exp_cnt));
    @(posedge clk); #1;
    got = snap(); exp = exp_q.pop_front(); tests++;
    if (got !== exp) begin fails++; $display("FAIL lu_bubble got=%h exp=%h", got, exp); end
    @(negedge clk); #1; tests++;
    if (StallD !== 1'b0) begin fails++; $display("FAIL lu_release got=%b exp=0", StallD); end
    exp_q.push_back(mk(1, 9, 3, 4, 0, 0, 8'h22, 0, exp_cnt));
    @(posedge clk); #1;
    got = snap(); exp = exp_q.pop_front(); tests++;
    if (got !== exp) begin fails++; $display("FAIL lu_capture got=%h exp=%h", got, exp); end
  endtask
  task automatic test_x0();
    @(negedge clk);
    set_d(1, 2, 0, 8'h33, 1, 0, 1);
    exp_q.push_back(mk(1, 1, 2, 0, 1, 0, 8'h33, 0, exp_cnt));
    @(posedge clk); #1;
    got = snap(); exp = exp_q.pop_front(); tests++;
    if (got !== exp) begin fails++; $display("FAIL x0_load got=%h exp=%h", got, exp); end
    @(negedge clk);
    set_d(0, 0, 5, 8'h44, 0, 0, 1);
    #1; tests++;
    if (StallD !== 1'b0) begin fails++; $display("FAIL x0_nostall got=%b exp=0", StallD); end
    exp_q.push_back(mk(1, 0, 0, 5, 0, 0, 8'h44, 0, exp_cnt));
    @(posedge clk); #1;
    got = snap(); exp = exp_q.pop_front(); tests++;
    if (got !== exp) begin fails++; $display("FAIL x0_capture got=%h exp=%h", got, exp); end
    tests++;
    if ({RegWE, MemWriteE, ALUSrcE, ALUCtrlE, RD2E, ImmE, PCE} !== {3'b100, 4'h2, 32'h1234, 32'h10, 32'h400}) begin
      fails++;
      $display("FAIL x0_fields got=%h exp=%h", {RegWE, MemWriteE, ALUSrcE, ALUCtrlE, RD2E, ImmE, PCE},
               {3'b100, 4'h2, 32'h1234, 32'h10, 32'h400});
    end
  endtask
  task automatic test_mul();
    @(negedge clk);
    set_d(5, 6, 7, 8'hAA, 0, 1, 1);
    exp_q.push_back(mk(1, 5, 6, 7, 0, 1, 8'hAA, 1, exp_cnt));
    @(posedge clk); #1;
    got = snap(); exp = exp_q.pop_front(); tests++;
    if (got !== exp) begin fails++; $display("FAIL mul_capture got=%h exp=%h", got, exp); end
    @(negedge clk);
    set_d(8, 9, 10, 8'hBB, 0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      if (i == 1) @(negedge clk);
      #1; tests++;
      if ({StallF, StallD} !== 2'b11) begin fails++; $display("FAIL mul_stall%0d got=%b exp=11", i, {StallF, StallD}); end
      exp_cnt++;
      exp_q.push_back(mk(1, 5, 6, 7, 0, 1, 8'hAA, i == 0, exp_cnt));
      @(posedge clk); #1;
      got = snap(); exp = exp_q.pop_front(); tests++;
      if (got !== exp) begin fails++; $display("FAIL mul_hold%0d got=%h exp=%h", i, got, exp); end
    end
    @(negedge clk); #1; tests++;
    if (StallD !== 1'b0) begin fails++; $display("FAIL mul_release got=%b exp=0", StallD); end
    exp_q.push_back(mk(1, 8, 9, 10, 0, 0, 8'hBB, 0, exp_cnt));
    @(posedge clk); #1;
    got = snap(); exp = exp_q.pop_front(); tests++;
    if (got !== exp) begin fails++; $display("FAIL mul_next got=%h exp=%h", got, exp); end
  endtask
  task automatic test_invalid();
    @(negedge clk);
    set_d(5, 6, 7, 8'h77, 0, 1, 0);
    exp_q.push_back(bubble(exp_cnt));
    @(posedge clk); #1;
    got = snap(); exp = exp_q.pop_front(); tests++;
    if (got !== exp) begin fails++; $display("FAIL invalid_mul got=%h exp=%h", got, exp); end
  endtask
  task automatic test_flush();
    @(negedge clk);
    set_d(1, 2, 9, 8'h11, 1, 0, 1);
    exp_q.push_back(mk(1, 1, 2, 9, 1, 0, 8'h11, 0, exp_cnt));
    @(posedge clk); #1;
    got = snap(); exp = exp_q.pop_front(); tests++;
    if (got !== exp) begin fails++; $display("FAIL flush_load got=%h exp=%h", got, exp); end
    @(negedge clk);
    set_d(9, 3, 4, 8'h22, 0, 0, 1);
    FlushE = 1;
    #1; tests++;
    if ({StallF, StallD} !== 2'b00) begin fails++; $display("FAIL flush_lu_stall got=%b exp=00", {StallF, StallD}); end
    exp_q.push_back(bubble(exp_cnt));
    @(posedge clk); #1;
    got = snap(); exp = exp_q.pop_front(); tests++;
    if (got !== exp) begin fails++; $display("FAIL flush_lu_bubble got=%h exp=%h", got, exp); end
    @(negedge clk);
    FlushE = 0;
    set_d(5, 6, 7, 8'hAA, 0, 1, 1);
    exp_q.push_back(mk(1, 5, 6, 7, 0, 1, 8'hAA, 1, exp_cnt));
    @(posedge clk); #1;
    got = snap(); exp = exp_q.pop_front(); tests++;
    if (got !== exp) begin fails++; $display("FAIL flush_mul_capture got=%h exp=%h", got, exp); end
    @(negedge clk);
    FlushE = 1;
    set_d(3, 4, 6, 8'h55, 0, 0, 1);
    #1; tests++;
    if (StallD !== 1'b0) begin fails++; $display("FAIL flush_mul_stall got=%b exp=0", StallD); end
    exp_q.push_back(bubble(exp_cnt));
    @(posedge clk); #1;
    got = snap(); exp = exp_q.pop_front(); tests++;
    if (got !== exp) begin fails++; $display("FAIL flush_mul_bubble got=%h exp=%h", got, exp); end
    @(negedge clk);
    FlushE = 0;
    #1; tests++;
    if (StallD !== 1'b0) begin fails++; $display("FAIL flush_resume_stall got=%b exp=0", StallD); end
    exp_q.push_back(mk(1, 3, 4, 6, 0, 0, 8'h55, 0, exp_cnt));
    @(posedge clk); #1;
    got = snap(); exp = exp_q.pop_front(); tests++;
    if (got !== exp) begin fails++; $display("FAIL flush_resume got=%h exp=%h", got, exp); end
  endtask
  task automatic test_reset_mid_mul();
    @(negedge clk);
    set_d(5, 6, 7, 8'hAA, 0, 1, 1);
    exp_q.push_back(mk(1, 5, 6, 7, 0, 1, 8'hAA, 1, exp_cnt));
    @(posedge clk); #1;
    got = snap(); exp = exp_q.pop_front(); tests++;
    if (got !== exp) begin fails++; $display("FAIL rstmul_capture got=%h exp=%h", got, exp); end
    #2;
    rst = 0;
    exp_cnt = 0;
    #1; tests++;
    if (snap() !== 43'd0 || {StallF, StallD, BusyE} !== 3'b000) begin
      fails++;
      $display("FAIL rstmul_clear got=%h stall=%b exp=0", snap(), {StallF, StallD, BusyE});
    end
    @(negedge clk);
    rst = 1;
    set_d(2, 3, 4, 8'h99, 0, 0, 1);
    #1; tests++;
    if (StallD !== 1'b0) begin fails++; $display("FAIL rstmul_nostall got=%b exp=0", StallD); end
    exp_q.push_back(mk(1, 2, 3, 4, 0, 0, 8'h99, 0, exp_cnt));
    @(posedge clk); #1;
    got = snap(); exp = exp_q.pop_front(); tests++;
    if (got !== exp) begin fails++; $display("FAIL rstmul_resume got=%h exp=%h", got, exp); end
  endtask
  task automatic test_saturate();
    @(negedge clk);
    force dut.stall_cnt = 16'hFFFE;
    #1;
    release dut.stall_cnt;
    exp_cnt = 16'hFFFE;
    set_d(5, 6, 7, 8'hAA, 0, 1, 1);
    exp_q.push_back(mk(1, 5, 6, 7, 0, 1, 8'hAA, 1, exp_cnt));
    @(posedge clk); #1;
    got = snap(); exp = exp_q.pop_front(); tests++;
    if (got !== exp) begin fails++; $display("FAIL sat_capture got=%h exp=%h", got, exp); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      set_d(1, 2, 9, 8'h11, 1, 0, 1);
      exp_cnt = 16'hFFFF;
      exp_q.push_back(mk(1, 5, 6, 7, 0, 1, 8'hAA, i == 0, exp_cnt));
      @(posedge clk); #1;
      got = snap(); exp = exp_q.pop_front(); tests++;
      if (got !== exp) begin fails++; $display("FAIL sat_hold%0d got=%h exp=%h", i, got, exp); end
    end
    @(negedge clk);
    exp_q.push_back(mk(1, 1, 2, 9, 1, 0, 8'h11, 0, exp_cnt));
    @(posedge clk); #1;
    got = snap(); exp = exp_q.pop_front(); tests++;
    if (got !== exp) begin fails++; $display("FAIL sat_load got=%h exp=%h", got, exp); end
    @(negedge clk);
    set_d(9, 3, 4, 8'h22, 0, 0, 1);
    #1; tests++;
    if (StallD !== 1'b1) begin fails++; $display("FAIL sat_stall got=%b exp=1", StallD); end
    exp_q.push_back(bubble(exp_cnt));
    @(posedge clk); #1;
    got = snap(); exp = exp_q.pop_front(); tests++;
    if (got !== exp) begin fails++; $display("FAIL sat_final got=%h exp=%h", got, exp); end
  endtask
  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_load_use();
    test_x0();
    test_mul();
    test_invalid();
    test_flush();
    test_reset_mid_mul();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
